// File: rtl/condicionador_botao.sv
// Pedestrian push-button conditioner for semaforo: synchronises and debounces bt_raw,
// latches the request until light A is green, emits one bt pulse, then rejects repeats.
module condicionador_botao #(
    parameter logic [7:0] DEBOUNCE = 8'd2,
    parameter logic [7:0] COOLDOWN = 8'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_raw,
    input  logic [2:0] A,
    output logic       bt,
    output logic       pendente,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        OCIOSO,
        PENDENTE,
        EMITE,
        ESPERA
    } estado_t;

    estado_t    estado;
    estado_t    estado_nxt;
    logic       s1;
    logic       s2;
    logic       deb_r;
    logic       deb;
    logic       deb_prev;
    logic       ev;
    logic [7:0] cnt_deb;
    logic [7:0] cnt_cool;
    logic [7:0] cnt_cool_nxt;

    // Only the verde bit of light A matters here.
    logic unused_a;
    assign unused_a = ^A[2:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bt_raw;
            s2 <= s1;
        end
    end

    // Debounced level moves only after DEBOUNCE consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_r   <= 1'b0;
            cnt_deb <= 8'd0;
        end else if (s2 == deb_r) begin
            cnt_deb <= 8'd0;
        end else if (cnt_deb + 8'd1 == DEBOUNCE) begin
            deb_r   <= s2;
            cnt_deb <= 8'd0;
        end else if (cnt_deb != 8'hFF) begin
            cnt_deb <= cnt_deb + 8'd1;
        end
    end

    assign deb = (DEBOUNCE == 8'd0) ? s2 : deb_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_prev <= 1'b0;
        end else begin
            deb_prev <= deb;
        end
    end

    assign ev = deb & ~deb_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= OCIOSO;
            cnt_cool <= 8'd0;
        end else begin
            estado   <= estado_nxt;
            cnt_cool <= cnt_cool_nxt;
        end
    end

    // Presses arriving outside OCIOSO are absorbed: one request, one pulse, no queue.
    always_comb begin
        estado_nxt   = estado;
        cnt_cool_nxt = cnt_cool;
        case (estado)
            OCIOSO: begin
                if (ev) begin
                    estado_nxt = PENDENTE;
                end
            end
            PENDENTE: begin
                if (A[0]) begin
                    estado_nxt = EMITE;
                end
            end
            EMITE: begin
                if (COOLDOWN == 8'd0) begin
                    estado_nxt = OCIOSO;
                end else begin
                    estado_nxt   = ESPERA;
                    cnt_cool_nxt = COOLDOWN - 8'd1;
                end
            end
            ESPERA: begin
                if (cnt_cool == 8'd0) begin
                    estado_nxt = OCIOSO;
                end else begin
                    cnt_cool_nxt = cnt_cool - 8'd1;
                end
            end
            default: begin
                estado_nxt = OCIOSO;
            end
        endcase
    end

    assign bt       = (estado == EMITE);
    assign pendente = (estado == PENDENTE);
    assign ocupado  = (estado == ESPERA);

endmodule

// File: tb/tb_condicionador_botao.sv
// Bench for condicionador_botao: default and bypass (DEBOUNCE=0, COOLDOWN=0) instances
// share stimulus; every cycle is compared against a request/cooldown reference model.
module tb_condicionador_botao;

    logic       clk = 1'b0;
    logic       rst;
    logic       bt_raw;
    logic [2:0] A;
    logic       bt_a, pend_a, ocup_a;
    logic       bt_b, pend_b, ocup_b;

    always #5 clk = ~clk;

    condicionador_botao dut_a (
        .clk(clk), .rst(rst), .bt_raw(bt_raw), .A(A),
        .bt(bt_a), .pendente(pend_a), .ocupado(ocup_a)
    );

    condicionador_botao #(.DEBOUNCE(8'd0), .COOLDOWN(8'd0)) dut_b (
        .clk(clk), .rst(rst), .bt_raw(bt_raw), .A(A),
        .bt(bt_b), .pendente(pend_b), .ocupado(ocup_b)
    );

    int checks   = 0;
    int failures = 0;
    int pulses[2];

    // Reference model, index 0 = default instance, 1 = bypass instance.
    int md[2] = '{2, 0};
    int mc[2] = '{3, 0};
    bit m_s1[2], m_s2[2], m_deb[2], m_prev[2];
    int m_run[2];
    bit m_pend[2], m_emit[2];
    int m_cool[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_run[i] = 0;
            m_pend[i] = 0; m_emit[i] = 0; m_cool[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit level;
            bit press;
            level = (md[i] == 0) ? m_s2[i] : m_deb[i];
            press = level && !m_prev[i];
            if (m_emit[i]) begin
                m_emit[i] = 0;
                m_cool[i] = mc[i];
            end else if (m_cool[i] > 0) begin
                m_cool[i] = m_cool[i] - 1;
            end else if (m_pend[i]) begin
                if (A[0]) begin
                    m_pend[i] = 0;
                    m_emit[i] = 1;
                end
            end else if (press) begin
                m_pend[i] = 1;
            end
            m_prev[i] = level;
            if (md[i] != 0) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= md[i]) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = bt_raw;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        chk("bt_a", bt_a, m_emit[0]);
        chk("pend_a", pend_a, m_pend[0]);
        chk("ocup_a", ocup_a, m_cool[0] > 0);
        chk("bt_b", bt_b, m_emit[1]);
        chk("pend_b", pend_b, m_pend[1]);
        chk("ocup_b", ocup_b, m_cool[1] > 0);
        if (bt_a) pulses[0]++;
        if (bt_b) pulses[1]++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold_raw;
        int hold_a;
        hold_raw = 0;
        hold_a   = 0;
        rst    = 1'b1;
        bt_raw = 1'b0;
        A      = 3'b001;
        model_reset();
        ticks(2);
        chk("rst_bt", bt_a, 1'b0);
        chk("rst_pend", pend_a, 1'b0);
        chk("rst_ocup", ocup_a, 1'b0);
        rst = 1'b0;
        ticks(3);

        // Clean press, A green: both instances, exact edge timing.
        pulses = '{0, 0};
        bt_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t1_bt", bt_a, k == 6);
            chk("t1_pend", pend_a, k == 5);
            chk("t1_ocup", ocup_a, k >= 7 && k <= 9);
            chk("t6_bt", bt_b, k == 4);
            chk("t6_pend", pend_b, k == 3);
            chk("t6_ocup", ocup_b, 1'b0);
        end
        chk_int("t1_pulses", pulses[0], 1);

        // Bypass instance: release, re-press two cycles later, expect a second pulse.
        bt_raw = 1'b0;
        ticks(2);
        bt_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6_ocup2", ocup_b, 1'b0);
        end
        chk_int("t6_pulses", pulses[1], 2);

        // Bounce: 1,0,1,0 then settle high.
        bt_raw = 1'b0;
        ticks(10);
        pulses = '{0, 0};
        for (int k = 0; k < 4; k++) begin
            bt_raw = (k % 2 == 0);
            tick();
            chk("t2_pend", pend_a, 1'b0);
            chk("t2_bt", bt_a, 1'b0);
        end
        bt_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t2_bt_time", bt_a, k == 6);
        end
        chk_int("t2_pulses", pulses[0], 1);

        // Wait for green.
        bt_raw = 1'b0;
        A = 3'b100;
        ticks(10);
        pulses = '{0, 0};
        bt_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t3_pend", pend_a, k >= 5);
            chk("t3_bt_red", bt_a, 1'b0);
        end
        A = 3'b001;
        tick();
        chk("t3_bt_green", bt_a, 1'b1);
        ticks(5);
        chk_int("t3_pulses", pulses[0], 1);

        // Cooldown rejection: second press lands while ocupado.
        bt_raw = 1'b0;
        ticks(10);
        pulses = '{0, 0};
        for (int k = 1; k <= 14; k++) begin
            bt_raw = (k <= 2 || k >= 5);
            tick();
            chk("t4_bt", bt_a, k == 6);
            chk("t4_pend", pend_a, k == 5);
        end
        chk_int("t4_pulses", pulses[0], 1);
        chk("t4_pend_end", pend_a, 1'b0);

        // Asynchronous reset while a request waits on red.
        bt_raw = 1'b0;
        A = 3'b100;
        ticks(10);
        bt_raw = 1'b1;
        ticks(8);
        chk("t5_pend_before", pend_a, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("t5_pend_rst", pend_a, 1'b0);
        chk("t5_bt_rst", bt_a, 1'b0);
        chk("t5_ocup_rst", ocup_a, 1'b0);
        chk("t5_pend_rst_b", pend_b, 1'b0);
        model_reset();
        bt_raw = 1'b0;
        ticks(2);
        rst = 1'b0;
        A = 3'b001;
        pulses = '{0, 0};
        ticks(12);
        chk_int("t5_pulses_a", pulses[0], 0);
        chk_int("t5_pulses_b", pulses[1], 0);

        // Randomised stimulus against the reference model.
        for (int n = 0; n < 600; n++) begin
            if (hold_raw == 0) begin
                bt_raw   = 1'($urandom_range(0, 1));
                hold_raw = $urandom_range(1, 8);
            end
            hold_raw--;
            if (hold_a == 0) begin
                A      = 3'($urandom_range(0, 7));
                hold_a = $urandom_range(1, 12);
            end
            hold_a--;
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
